mips_run_dump_ctrl: RTL
=======================

Name: mips_run_dump_ctrl

Overview:
- Synthesisable run controller for the MIPS pipeline core.
- Holds the core in reset, releases it on a start pulse and watches `fin`, with a watchdog timeout.
- When the run ends, it reads a configurable list of data-memory words and streams them out on a valid/ready port.
- Replaces hard-coded bench sequencing (fixed three-word dump, ad-hoc forced termination) with one reusable block for FPGA and simulation harnesses.

Parameters:
- DW, 32, data-memory word width.
- AW, 8, data-memory word-address width.
- DUMP_CNT, 3, number of words dumped per run (≥1).
- RST_CYCLES, 4, cycles `cpu_rstn` is held low after start (≥1).
- TIMEOUT, 1024, run-cycle limit before the watchdog fires (≥2).
- TW, 16, width of the run-cycle counter (2^TW > TIMEOUT).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run. Honoured only in IDLE or DONE.
- dump_addr_list  in  DUMP_CNT*AW  flattened address table. Entry i is bits [i*AW +: AW]; entry 0 is dumped first.
- cpu_rstn  out  1  drives the core's active-low `pcclr`.
- cpu_fin  in  1  core's `fin` flag (level).
- dmem_raddr  out  AW  read address to the data-memory read port.
- dmem_rdata  in  DW  read data; synchronous read, valid 1 cycle after the address.
- dump_valid  out  1  dump word available.
- dump_ready  in  1  consumer accepts the word when valid && ready.
- dump_addr  out  AW  address of the current dump word.
- dump_data  out  DW  data of the current dump word.
- dump_last  out  1  high with the final word of the run.
- busy  out  1  high in RESET_CPU, RUN and DUMP.
- done  out  1  high in DONE.
- timed_out  out  1  sticky; set when the watchdog fires, cleared on start or rst.
- run_cycles  out  TW  cycles spent in RUN in the last run; frozen after RUN exits.

Behaviour:
- Reset values:
  - state = IDLE; cpu_rstn = 0; all other outputs = 0; internal index and counters = 0.
- States and transitions:
  - IDLE: cpu_rstn = 0. On start → RESET_CPU; clear timed_out and run_cycles; load the reset counter.
  - RESET_CPU: cpu_rstn = 0 for exactly RST_CYCLES cycles, then → RUN.
  - RUN: cpu_rstn = 1; run_cycles increments every cycle.
    - Exit on a rising edge of cpu_fin, detected against a register that is cleared on entry to RUN. A fin level left high from a previous run is therefore ignored until it falls and rises again.
    - Watchdog: run_cycles == TIMEOUT-1 with no fin edge → set timed_out, → DUMP.
    - If the fin edge and the timeout occur in the same cycle, fin wins and timed_out stays 0.
  - DUMP: cpu_rstn remains 1 (data memory must stay intact). Per entry i:
    - Cycle A: dmem_raddr = entry i.
    - Cycle B: capture dmem_rdata into dump_data; assert dump_valid; dump_addr = entry i; dump_last = (i == DUMP_CNT-1).
    - Hold dump_valid, dump_addr, dump_data and dump_last stable until a ready handshake.
    - After the handshake, advance to i+1. The earliest next valid is 2 cycles later.
    - Handshake on the last entry → DONE.
  - DONE: done = 1; cpu_rstn = 1. On start → RESET_CPU (re-run). done drops the cycle after start.
- start outside IDLE/DONE is ignored.
- rst in any state, including mid-dump with valid pending: next cycle is IDLE, dump_valid = 0, cpu_rstn = 0. Nothing is replayed.
- dump_ready while dump_valid = 0 has no effect.
- busy = (state ∈ {RESET_CPU, RUN, DUMP}).

Optional Feature:
- Macro: MIPS_RUN_DUMP_CYCLES_EN.
- Defined: the dump carries one extra beat after the address list.
  - dump_addr = all ones; dump_data = run_cycles zero-extended to DW.
  - dump_last moves to this beat.
  - The beat is presented in the cycle after the last list handshake, with no memory read.
- Undefined: exactly DUMP_CNT beats are sent. run_cycles is still available as a port.

Decomposition:
- Package `mips_run_dump_pkg` holds:
  - the state enum (IDLE, RESET_CPU, RUN, DUMP, DONE);
  - the localparam for the all-ones cycle-count address tag.
- One sub-module, `mips_run_watchdog`: cycle counter with clear, enable and terminal flag. It produces run_cycles and the timeout strobe.

Test Plan:
- Normal run. Setup: list {1,4,16}; mem[1]=0xA, mem[4]=0xB, mem[16]=0xC; fin rises 40 cycles into RUN; ready tied 1. Required: beats (1,0xA), (4,0xB), (16,0xC,last); then done=1, timed_out=0, run_cycles=40.
- Backpressure. Setup: ready low 5 cycles on beat 2. Required: addr 4 / data 0xB held stable 5 cycles; no beat dropped or duplicated.
- Watchdog. Setup: TIMEOUT=64; fin never rises. Required: timed_out=1 at RUN cycle 64; full dump still emitted; done=1.
- Stale fin and ignored start. Setup: fin held high from the previous run; start pulsed during RUN. Required: no early exit; second start ignored; exit only on a fresh fin edge.
- Reset mid-dump. Setup: rst asserted while beat 2 is valid. Required: next cycle IDLE, dump_valid=0, cpu_rstn=0; a subsequent start produces a clean run from entry 0.
- MIPS_RUN_DUMP_CYCLES_EN defined. Setup: normal run above. Required: 4th beat addr=0xFF, data=40, last=1 only on that beat.

Source files
------------

// File: rtl/mips_run_dump_pkg.sv
// Shared types for the MIPS run/dump controller: FSM state encoding and the
// address tag that marks the optional cycle-count beat.
package mips_run_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET_CPU,
    RUN,
    DUMP,
    DONE
  } state_t;

  // Truncated to the address width at the point of use, so any AW gets all ones.
  localparam logic [255:0] CYC_ADDR_TAG = '1;

endpackage

// File: rtl/mips_run_watchdog.sv
// Run-cycle counter with synchronous clear and count enable; flags the cycle
// in which the count reaches TIMEOUT-1.
module mips_run_watchdog #(
  parameter int TW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [TW-1:0] count,
  output logic          expired
);

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its neighbours, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mips_run_dump_ctrl.sv
// Run controller: holds the core in reset, runs it until fin or watchdog, then
// streams a list of data-memory words. MIPS_RUN_DUMP_CYCLES_EN adds a final
// beat carrying run_cycles.
module mips_run_dump_ctrl
  import mips_run_dump_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 8,
  parameter int DUMP_CNT   = 3,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 1024,
  parameter int TW         = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DUMP_CNT*AW-1:0] dump_addr_list,
  output logic                   cpu_rstn,
  input  logic                   cpu_fin,
  output logic [AW-1:0]          dmem_raddr,
  input  logic [DW-1:0]          dmem_rdata,
  output logic                   dump_valid,
  input  logic                   dump_ready,
  output logic [AW-1:0]          dump_addr,
  output logic [DW-1:0]          dump_data,
  output logic                   dump_last,
  output logic                   busy,
  output logic                   done,
  output logic                   timed_out,
  output logic [TW-1:0]          run_cycles
);

  localparam int IW  = (DUMP_CNT > 1) ? $clog2(DUMP_CNT) : 1;
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DUMP_CNT - 1);

`ifdef MIPS_RUN_DUMP_CYCLES_EN
  localparam bit CYC_BEAT_EN = 1'b1;
`else
  localparam bit CYC_BEAT_EN = 1'b0;
`endif

  state_t         state, state_nxt;
  logic [RCW-1:0] rst_cnt;
  logic [IW-1:0]  idx;
  logic           phase_b;    // word for idx is being presented
  logic           first_b;    // first presentation cycle: rdata is live
  logic           cyc_beat;
  logic           fin_armed;  // fin has been seen low since entering RUN
  logic [DW-1:0]  data_q;
  logic [AW-1:0]  entry;
  logic           start_ok, fin_hit, wd_expired, handshake, run_end;

  assign entry     = dump_addr_list[idx*AW +: AW];
  assign start_ok  = start && (state == IDLE || state == DONE);
  assign fin_hit   = (state == RUN) && cpu_fin && fin_armed;
  assign handshake = dump_valid && dump_ready;
  assign run_end   = handshake && (CYC_BEAT_EN ? cyc_beat : (phase_b && idx == LAST_IDX));

  mips_run_watchdog #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_ok),
    .en      (state == RUN),
    .count   (run_cycles),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)            state_nxt = RESET_CPU;
      RESET_CPU:  if (rst_cnt == '0)    state_nxt = RUN;
      RUN:        if (fin_hit || wd_expired) state_nxt = DUMP;
      DUMP:       if (run_end)          state_nxt = DONE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_rstn   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    dmem_raddr = '0;
    dump_valid = 1'b0;
    dump_addr  = '0;
    dump_data  = '0;
    dump_last  = 1'b0;
    case (state)
      RESET_CPU: busy = 1'b1;
      RUN: begin
        busy     = 1'b1;
        cpu_rstn = 1'b1;
      end
      DUMP: begin
        busy     = 1'b1;
        cpu_rstn = 1'b1;
        if (cyc_beat) begin
          dump_valid = 1'b1;
          dump_addr  = AW'(CYC_ADDR_TAG);
          dump_data  = DW'(run_cycles);
          dump_last  = 1'b1;
        end else if (phase_b) begin
          dump_valid = 1'b1;
          dump_addr  = entry;
          dump_data  = first_b ? dmem_rdata : data_q;
          dump_last  = !CYC_BEAT_EN && (idx == LAST_IDX);
        end else begin
          dmem_raddr = entry;
        end
      end
      DONE: begin
        done     = 1'b1;
        cpu_rstn = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_cnt   <= '0;
      idx       <= '0;
      phase_b   <= 1'b0;
      first_b   <= 1'b0;
      cyc_beat  <= 1'b0;
      fin_armed <= 1'b0;
      data_q    <= '0;
      timed_out <= 1'b0;
    end else begin
      fin_armed <= (state == RUN) && (fin_armed || !cpu_fin);

      if (start_ok) begin
        rst_cnt   <= RCW'(RST_CYCLES - 1);
        timed_out <= 1'b0;
      end else if (state == RESET_CPU && rst_cnt != '0) begin
        rst_cnt <= rst_cnt - 1'b1;
      end

      if (state == RUN && wd_expired && !fin_hit) begin
        timed_out <= 1'b1;
      end

      if (state != DUMP) begin
        idx      <= '0;
        phase_b  <= 1'b0;
        first_b  <= 1'b0;
        cyc_beat <= 1'b0;
      end else if (!phase_b && !cyc_beat) begin
        phase_b <= 1'b1;
        first_b <= 1'b1;
      end else begin
        // Freeze the word so the beat stays stable however long ready is low.
        if (first_b) begin
          data_q <= dmem_rdata;
        end
        first_b <= 1'b0;
        if (handshake && phase_b) begin
          phase_b <= 1'b0;
          if (idx == LAST_IDX) begin
            cyc_beat <= CYC_BEAT_EN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
      end
    end
  end

endmodule
